// File: rtl/button_debouncer_if.sv
// Button pin / conditioned-level bundle between the board pins and the debouncer.
// Channel [0] is button1 and [1] is button2.
interface button_debouncer_if;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_debouncer.sv
// Two-channel push-button conditioner: 2-flop synchroniser, polarity fix and
// a per-channel debounce FSM producing a clean level plus press/release strobes.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  button_debouncer_if.slave   btn
);

  localparam int unsigned NCH = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  logic [NCH-1:0]       s1;
  logic [NCH-1:0]       s2;
  logic [NCH-1:0]       samp;
  state_t               state_q [NCH];
  state_t               state_d [NCH];
  logic [CNT_WIDTH-1:0] cnt_q   [NCH];
  logic [CNT_WIDTH-1:0] cnt_d   [NCH];
  logic [NCH-1:0]       level_q;
  logic [NCH-1:0]       level_d;
  logic [NCH-1:0]       press_q;
  logic [NCH-1:0]       press_d;
  logic [NCH-1:0]       release_q;
  logic [NCH-1:0]       release_d;

  // samp is 1 when the synchronised pin reads "pressed"
  assign samp = s2 ^ {NCH{ACTIVE_LOW}};

  // State register, synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= {NCH{ACTIVE_LOW}};
      s2        <= {NCH{ACTIVE_LOW}};
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1        <= btn.btn_raw;
      s2        <= s1;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state and stability counter; any bounce drops back and restarts the count
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        RELEASED: begin
          if (samp[i]) begin
            state_d[i] = PRESS_PEND;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        PRESS_PEND: begin
          if (!samp[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!samp[i]) begin
            state_d[i] = RELEASE_PEND;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        RELEASE_PEND: begin
          if (samp[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output decode: strobes fire only on the accepting transition out of a pending state
  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NCH; i++) begin
      level_d[i]   = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_PEND);
      press_d[i]   = (state_q[i] == PRESS_PEND) && (state_d[i] == PRESSED);
      release_d[i] = (state_q[i] == RELEASE_PEND) && (state_d[i] == RELEASED);
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random pin activity,
// all checked against a run-length reference model of the acceptance rule.
module tb_button_debouncer;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  button_debouncer_if bif ();

  button_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (16),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(bif)
  );

  // Reference model: pins reach the filter two edges late; a level flips once
  // the filtered pin has disagreed with it for D consecutive edges.
  logic [1:0] m_p1 = 2'b11;
  logic [1:0] m_p2 = 2'b11;
  logic [1:0] m_level = 2'b00;
  logic [1:0] m_press = 2'b00;
  logic [1:0] m_rel = 2'b00;
  int         m_run [2] = '{0, 0};

  always @(posedge clk) begin
    if (rst) begin
      m_p1 = 2'b11;
      m_p2 = 2'b11;
      m_level = 2'b00;
      m_press = 2'b00;
      m_rel = 2'b00;
      m_run[0] = 0;
      m_run[1] = 0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        logic pressed_now;
        pressed_now = ~m_p2[ch];
        m_press[ch] = 1'b0;
        m_rel[ch] = 1'b0;
        if (pressed_now != m_level[ch]) begin
          m_run[ch] = m_run[ch] + 1;
          if (m_run[ch] == D) begin
            m_level[ch] = pressed_now;
            if (pressed_now) m_press[ch] = 1'b1;
            else m_rel[ch] = 1'b1;
            m_run[ch] = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_p2 = m_p1;
      m_p1 = bif.btn_raw;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bif.btn_raw = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_during k=%0d: got %b expected 000000", k,
                 {bif.btn_level, bif.btn_press, bif.btn_release});
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_after k=%0d: got %b expected 000000", k,
                 {bif.btn_level, bif.btn_press, bif.btn_release});
      end
    end
  endtask

  task automatic test_clean_press();
    for (int t = 0; t < 8; t++) begin
      bif.btn_raw = 2'b10;
      @(negedge clk);
      n_checks++;
      if (bif.btn_level[0] !== (t >= 5) || bif.btn_press[0] !== (t == 5)) begin
        n_fail++;
        $display("FAIL clean_press t=%0d: level/press got %b%b expected %b%b", t,
                 bif.btn_level[0], bif.btn_press[0], t >= 5, t == 5);
      end
      n_checks++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL clean_press_model t=%0d: got %b expected %b", t,
                 {bif.btn_level, bif.btn_press, bif.btn_release}, {m_level, m_press, m_rel});
      end
    end
  endtask

  task automatic test_release();
    for (int t = 0; t < 8; t++) begin
      bif.btn_raw = 2'b11;
      @(negedge clk);
      n_checks++;
      if (bif.btn_level[0] !== (t < 5) || bif.btn_release[0] !== (t == 5)
          || bif.btn_press[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL release t=%0d: level/press/release got %b%b%b expected %b0%b", t,
                 bif.btn_level[0], bif.btn_press[0], bif.btn_release[0], t < 5, t == 5);
      end
    end
  endtask

  task automatic test_bounce();
    int presses = 0;
    for (int t = 0; t < 12; t++) begin
      bif.btn_raw = (t == 3) ? 2'b11 : 2'b10;
      @(negedge clk);
      if (bif.btn_press[0] === 1'b1) presses++;
      n_checks++;
      if (bif.btn_level[0] !== (t >= 9) || bif.btn_press[0] !== (t == 9)) begin
        n_fail++;
        $display("FAIL bounce t=%0d: level/press got %b%b expected %b%b", t,
                 bif.btn_level[0], bif.btn_press[0], t >= 9, t == 9);
      end
    end
    n_checks++;
    if (presses != 1) begin
      n_fail++;
      $display("FAIL bounce_strobe_count: got %0d expected 1", presses);
    end
  endtask

  task automatic test_both_channels();
    for (int t = 0; t < 8; t++) begin
      bif.btn_raw = 2'b00;
      @(negedge clk);
      n_checks++;
      if (bif.btn_level !== ((t >= 5) ? 2'b11 : 2'b00)
          || bif.btn_press !== ((t == 5) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL both_press t=%0d: level=%b press=%b expected level=%b press=%b", t,
                 bif.btn_level, bif.btn_press, (t >= 5) ? 2'b11 : 2'b00,
                 (t == 5) ? 2'b11 : 2'b00);
      end
    end
    for (int t = 0; t < 8; t++) begin
      bif.btn_raw = 2'b11;
      @(negedge clk);
      n_checks++;
      if (bif.btn_level !== ((t < 5) ? 2'b11 : 2'b00)
          || bif.btn_release !== ((t == 5) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL both_release t=%0d: level=%b release=%b", t,
                 bif.btn_level, bif.btn_release);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    for (int t = 0; t < 3; t++) begin
      bif.btn_raw = 2'b10;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bif.btn_level !== 2'b00 || bif.btn_press !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_in_reset: level=%b press=%b expected 00 00",
               bif.btn_level, bif.btn_press);
    end
    rst = 1'b0;
    for (int u = 0; u < 8; u++) begin
      @(negedge clk);
      n_checks++;
      if (bif.btn_level[0] !== (u >= 5) || bif.btn_press[0] !== (u == 5)) begin
        n_fail++;
        $display("FAIL reset_mid u=%0d: level/press got %b%b expected %b%b", u,
                 bif.btn_level[0], bif.btn_press[0], u >= 5, u == 5);
      end
    end
    for (int t = 0; t < 8; t++) begin
      bif.btn_raw = 2'b11;
      @(negedge clk);
    end
    n_checks++;
    if (bif.btn_level !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_release: level=%b expected 00", bif.btn_level);
    end
  endtask

  task automatic test_random(input int cycles);
    logic [1:0] pins = 2'b11;
    for (int c = 0; c < cycles; c++) begin
      for (int ch = 0; ch < 2; ch++)
        if ($urandom_range(5, 0) == 0) pins[ch] = ~pins[ch];
      bif.btn_raw = pins;
      rst = ($urandom_range(399, 0) == 0);
      @(negedge clk);
      n_checks++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL random c=%0d: lvl/prs/rel got %b expected %b", c,
                 {bif.btn_level, bif.btn_press, bif.btn_release}, {m_level, m_press, m_rel});
      end
      n_checks++;
      if ((bif.btn_press & bif.btn_release) !== 2'b00) begin
        n_fail++;
        $display("FAIL random_strobe_overlap c=%0d: press=%b release=%b", c,
                 bif.btn_press, bif.btn_release);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bif.btn_raw = 2'b11;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_release();
    test_both_channels();
    test_reset_mid_count();
    test_random(4000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
